// File: rtl/irq_pkg.sv
// irq_pkg: shared FSM state type and the int_no width helper for the interrupt controller
package irq_pkg;
  typedef enum logic {IDLE, REQ} state_e;
  function automatic int idw(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/irq_sync_edge.sv
// irq_sync_edge: 2-flop synchronizer plus rising-edge pulse; ports clk, rst, d_i (async line), rise_o (one-cycle pulse)
module irq_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o
);
  logic [2:0] s_q;
  always_ff @(posedge clk) s_q <= rst ? '0 : {s_q[1:0], d_i};
  // s_q[1] is the synchronized level, s_q[2] its previous value
  assign rise_o = s_q[1] & ~s_q[2];
endmodule

// File: rtl/irq_controller.sv
// irq_controller: prioritized interrupt controller with pending/in-service/mask status, handler vectors, optional nesting (macro IRQ_NEST_EN); ports clk, rst, irq_in, ie, mask_we, mask_wdata, int_ack, eret -> int_req, int_no, int_vec, pending, in_service, mask
module irq_controller
  import irq_pkg::*;
#(
  parameter int          NUM_IRQ    = 3,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0D00,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0100,
  localparam int         IDW        = idw(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               ie,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               int_ack,
  input  logic               eret,
  output logic               int_req,
  output logic [IDW-1:0]     int_no,
  output logic [31:0]        int_vec,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] in_service,
  output logic [NUM_IRQ-1:0] mask
);
  logic [NUM_IRQ-1:0] rise, pending_q, in_service_q, mask_q, elig, req_oh, ack_oh, eret_oh;
  logic [IDW-1:0] int_no_q, int_no_d, top, lvl;
  logic [31:0] idx;
  logic can_req, ack;
  state_e state_q, state_d;
  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_sync
    irq_sync_edge u_sync (.clk(clk), .rst(rst), .d_i(irq_in[i]), .rise_o(rise[i]));
  end
  assign elig = pending_q & ~mask_q;
  always_comb begin
    top = '0;
    lvl = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      top = elig[i] ? IDW'(i + 1) : top;
      lvl = in_service_q[i] ? IDW'(i + 1) : lvl;
    end
  end
  always_comb begin
    req_oh = '0;
    eret_oh = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      req_oh[i] = int_no_q == IDW'(i + 1);
      eret_oh[i] = eret && lvl == IDW'(i + 1);
    end
  end
`ifdef IRQ_NEST_EN
  assign can_req = top > lvl;
`else
  assign can_req = top != '0 && in_service_q == '0;
`endif
  always_comb begin
    state_d = state_q;
    int_no_d = int_no_q;
    ack = 1'b0;
    if (state_q == IDLE) begin
      if (ie && can_req) begin
        state_d = REQ;
        int_no_d = top;
      end
    end else if (int_ack) begin
      ack = 1'b1;
      state_d = IDLE;
      int_no_d = '0;
    end else if (!ie || (elig & req_oh) == '0) begin
      state_d = IDLE;
      int_no_d = '0;
    end else begin
      int_no_d = top > int_no_q ? top : int_no_q;
    end
  end
  assign ack_oh = ack ? req_oh : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      int_no_q <= '0;
      pending_q <= '0;
      in_service_q <= '0;
      mask_q <= '0;
    end else begin
      state_q <= state_d;
      int_no_q <= int_no_d;
      // a fresh edge on the acked channel re-sets pending
      pending_q <= (pending_q & ~ack_oh) | rise;
      // eret retires the pre-cycle top level before the acked bit is added
      in_service_q <= (in_service_q & ~eret_oh) | ack_oh;
      mask_q <= mask_we ? mask_wdata : mask_q;
    end
  end
  assign idx = int_no_q == '0 ? '0 : 32'(int_no_q) - 32'd1;
  assign int_vec = VEC_BASE + idx * VEC_STRIDE;
  assign int_req = state_q == REQ;
  assign int_no = int_no_q;
  assign pending = pending_q;
  assign in_service = in_service_q;
  assign mask = mask_q;
endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 Parameters: NUM_IRQ, default 3, channel count (1..16).
REQ-002 Parameters: VEC_BASE, default 32'h0000_0D00, vector of channel 1.
REQ-003 Parameters: VEC_STRIDE, default 32'h0000_0100, vector spacing per channel.
REQ-004 Ports: clk  in  1  sole clock; all state on posedge clk.
REQ-005 Ports: rst  in  1  synchronous, active-high reset.
REQ-006 Ports: irq_in  in  NUM_IRQ  raw asynchronous request lines (buttons).
REQ-007 Ports: ie  in  1  global interrupt enable from the CPU IE register.
REQ-008 Ports: mask_we  in  1  mask write strobe; mask_wdata  in  NUM_IRQ  new mask (1 = masked).
REQ-009 Ports: int_ack  in  1  one-cycle pulse, CPU has redirected to int_vec.
REQ-010 Ports: eret  in  1  one-cycle pulse, handler returned.
REQ-011 Ports: int_req  out  1  interrupt request to the pipeline, registered.
REQ-012 Ports: int_no  out  IDW=$clog2(NUM_IRQ+1)  1-based requested channel, 0 = none.
REQ-013 Ports: int_vec  out  32  handler address of int_no.
REQ-014 Ports: pending, in_service, mask  out  NUM_IRQ each  status registers.

Function
REQ-015 Each irq_in bit SHALL pass a 2-flop synchronizer; a synchronized 0->1 transition SHALL set pending[i] on the following edge.
REQ-016 Priority: higher index wins; channel NUM_IRQ-1 (int_no = NUM_IRQ) is highest.
REQ-017 eligible = pending & ~mask; level = index+1 of highest in_service bit, 0 if none.
REQ-018 FSM states IDLE, REQ; IDLE->REQ when ie=1 and highest eligible index+1 > level; int_req=1 only in REQ.
REQ-019 Latency: irq_in rise to int_req=1 SHALL be exactly 4 clk edges with channel unmasked, ie=1, level 0.
REQ-020 In REQ, int_no SHALL upgrade to a higher-priority eligible channel, never downgrade; REQ->IDLE if ie=0 or the requested channel becomes ineligible.
REQ-021 int_ack in REQ: clear pending[int_no-1], set in_service[int_no-1], go IDLE; int_req=0 next cycle. int_ack in IDLE SHALL be ignored.
REQ-022 eret SHALL clear the highest set in_service bit; eret with in_service=0 ignored.
REQ-023 int_ack and eret in the same cycle: eret clears from the pre-cycle in_service, then ack's bit is set.
REQ-024 New edge on the channel being acked in the same cycle: pending stays 1 (set wins).
REQ-025 Mask write takes effect next cycle; masking never clears pending.
REQ-026 int_vec = VEC_BASE + (int_no-1)*VEC_STRIDE, modulo 2^32; int_vec = VEC_BASE when int_no = 0.

Reset
REQ-027 On rst: synchronizers, pending, in_service, mask = 0; FSM = IDLE; int_req = 0, int_no = 0.
REQ-028 rst mid-REQ or mid-handler SHALL discard all state; edges seen before reset SHALL NOT reappear.

Configuration
REQ-029 Macro IRQ_NEST_EN defined: nesting per REQ-017/018.
REQ-030 Macro IRQ_NEST_EN undefined: IDLE->REQ requires in_service = 0; at most one in_service bit is ever set.

Structure
REQ-031 Package irq_pkg SHALL hold the FSM state enum and the IDW width function.
REQ-032 Sub-module irq_sync_edge (one per channel: synchronizer plus rising-edge pulse).

Verification
REQ-033 Channel 1 rises at cycle 0, ie=1 -> int_req=1, int_no=2, int_vec=32'h0E00 after cycle 4; ack -> pending=3'b000, in_service=3'b010.
REQ-034 Channels 0 and 2 rise together -> int_no=3, int_vec=32'h0F00; after ack, int_no=1 requested only after eret.
REQ-035 NEST_EN: in_service=3'b001, channel 2 rises -> int_req with int_no=3; NEST off -> no request until eret.
REQ-036 mask=3'b010, channel 1 rises -> pending=3'b010, int_req stays 0; mask=0 -> int_req one cycle later.
REQ-037 ie drops while in REQ -> int_req=0 next cycle, pending kept; ie=1 -> re-request same int_no.
REQ-038 rst asserted with pending=3'b101, in_service=3'b010 -> all status 0, int_req=0 next cycle.
